// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter for a register bank: one valid/ready grant per cycle,
// registered one-hot enable and shared data bus towards the bank.
module reg_write_arbiter #(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned NUM_REGS = 8,
   parameter int unsigned ADDR_W   = 3,
   parameter int unsigned ID_W     = 2
) (
   input  logic                      clk,
   input  logic                      r_n,
   input  logic                      stall,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*WIDTH-1:0]  req_data,
   output logic [NUM_REGS-1:0]       wr_en,
   output logic [WIDTH-1:0]          wr_data,
   output logic [ID_W-1:0]           grant_id,
   output logic                      addr_err
);

   logic [ID_W-1:0]     ptr_q, ptr_d;
   logic [ID_W-1:0]     gnt_idx;
   logic                xfer;
   logic [ADDR_W-1:0]   sel_addr;
   logic [WIDTH-1:0]    sel_data;
   logic                in_range;
   logic [NUM_REGS-1:0] wr_en_d;

   // Grant: first valid requester scanning from ptr, wrapping modulo NUM_REQ.
   always_comb begin
      int unsigned idx;
      req_ready = '0;
      xfer      = 1'b0;
      gnt_idx   = '0;
      idx       = 0;
      // Ready is forced low while reset is asserted, independent of the registers.
      if (r_n && !stall) begin
         for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!xfer && req_valid[idx]) begin
               xfer           = 1'b1;
               gnt_idx        = ID_W'(idx);
               req_ready[idx] = 1'b1;
            end
         end
      end
   end

   // Mux the granted request and decode its address into a one-hot enable.
   always_comb begin
      sel_addr = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
      sel_data = req_data[int'(gnt_idx)*WIDTH +: WIDTH];
      in_range = (32'(sel_addr) < NUM_REGS);
      wr_en_d  = '0;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
         wr_en_d[r] = xfer && in_range && (32'(sel_addr) == r);
      end
      ptr_d = ptr_q;
      if (xfer) begin
         ptr_d = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
      end
   end

   // Pointer and output stage; out-of-range requests are consumed but never enable a register.
   always_ff @(posedge clk or negedge r_n) begin
      if (!r_n) begin
         ptr_q    <= '0;
         wr_en    <= '0;
         wr_data  <= '0;
         grant_id <= '0;
         addr_err <= 1'b0;
      end else begin
         ptr_q    <= ptr_d;
         wr_en    <= wr_en_d;
         addr_err <= xfer && !in_range;
         if (xfer) begin
            wr_data  <= sel_data;
            grant_id <= gnt_idx;
         end
      end
   end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter (NUM_REGS=6 to exercise the out-of-range path).
module tb_reg_write_arbiter;

   localparam int unsigned NUM_REQ  = 4;
   localparam int unsigned WIDTH    = 32;
   localparam int unsigned NUM_REGS = 6;
   localparam int unsigned ADDR_W   = 3;
   localparam int unsigned ID_W     = 2;

   logic                      clk = 1'b0;
   logic                      r_n;
   logic                      stall;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*WIDTH-1:0]  req_data;
   logic [NUM_REGS-1:0]       wr_en;
   logic [WIDTH-1:0]          wr_data;
   logic [ID_W-1:0]           grant_id;
   logic                      addr_err;

   int checks   = 0;
   int failures = 0;

   reg_write_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .WIDTH    (WIDTH),
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W),
      .ID_W     (ID_W)
   ) dut (
      .clk       (clk),
      .r_n       (r_n),
      .stall     (stall),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .grant_id  (grant_id),
      .addr_err  (addr_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      r_n       = 1'b0;
      stall     = 1'b0;
      req_valid = '0;
      req_addr  = '0;
      req_data  = '0;
      #2;
      req_valid = 4'b1111;
      #1;
      chk("rst_ready", 64'(req_ready), 64'h0);
      chk("rst_wr_en", 64'(wr_en), 64'h0);
      chk("rst_wr_data", 64'(wr_data), 64'h0);
      chk("rst_grant_id", 64'(grant_id), 64'h0);
      chk("rst_addr_err", 64'(addr_err), 64'h0);
      req_valid = '0;
      step();
      step();
      r_n = 1'b1;

      // Single request to register 5.
      req_valid       = 4'b0001;
      req_addr[2:0]   = 3'd5;
      req_data[31:0]  = 32'hDEADBEEF;
      #1;
      chk("t1_ready", 64'(req_ready), 64'h1);
      step();
      req_valid = '0;
      chk("t1_wr_en", 64'(wr_en), 64'h20);
      chk("t1_wr_data", 64'(wr_data), 64'hDEADBEEF);
      chk("t1_grant_id", 64'(grant_id), 64'h0);
      chk("t1_addr_err", 64'(addr_err), 64'h0);
      step();
      chk("t1_idle_wr_en", 64'(wr_en), 64'h0);
      chk("t1_hold_data", 64'(wr_data), 64'hDEADBEEF);

      // ptr=1: lone requester 3 (addr 4) brings ptr back to 0.
      req_addr  = {3'd4, 3'd3, 3'd2, 3'd1};
      req_data  = {32'h1003, 32'h1002, 32'h1001, 32'h1000};
      req_valid = 4'b1000;
      #1;
      chk("t2_pre_ready", 64'(req_ready), 64'h8);
      step();
      chk("t2_pre_gid", 64'(grant_id), 64'h3);
      chk("t2_pre_wr_en", 64'(wr_en), 64'h10);

      // All four requesting: strict rotation 0,1,2,3,0,1,2,3.
      req_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk("t2_ready", 64'(req_ready), 64'(1 << (k % 4)));
         step();
         chk("t2_gid", 64'(grant_id), 64'(k % 4));
         chk("t2_wr_en", 64'(wr_en), 64'(1 << ((k % 4) + 1)));
         chk("t2_wr_data", 64'(wr_data), 64'(32'h1000 + (k % 4)));
      end
      req_valid = '0;

      // Move ptr to 2, then 0011 must wrap around to requester 0.
      req_valid = 4'b0010;
      #1;
      chk("t3_pre_ready", 64'(req_ready), 64'h2);
      step();
      req_valid = 4'b0011;
      #1;
      chk("t3_wrap_ready", 64'(req_ready), 64'h1);
      step();
      chk("t3_wrap_gid", 64'(grant_id), 64'h0);
      chk("t3_wrap_wr_en", 64'(wr_en), 64'h2);
      // ptr now 1; probe then withdraw before the edge.
      req_valid = 4'b1111;
      #1;
      chk("t3_ptr_probe", 64'(req_ready), 64'h2);
      req_valid = '0;
      step();
      chk("t3_withdraw_wr_en", 64'(wr_en), 64'h0);

      // Stall for 3 cycles with everyone requesting.
      stall     = 1'b1;
      req_valid = 4'b1111;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("t4_stall_ready", 64'(req_ready), 64'h0);
         step();
         chk("t4_stall_wr_en", 64'(wr_en), 64'h0);
      end
      stall = 1'b0;
      #1;
      chk("t4_post_ready", 64'(req_ready), 64'h2);
      step();
      req_valid = '0;
      chk("t4_post_gid", 64'(grant_id), 64'h1);
      chk("t4_post_wr_en", 64'(wr_en), 64'h4);

      // Requester 1 targets address 7 (>= NUM_REGS); ptr is 2.
      req_addr[5:3] = 3'd7;
      req_valid     = 4'b0010;
      #1;
      chk("t5_ready", 64'(req_ready), 64'h2);
      step();
      req_valid = '0;
      chk("t5_wr_en", 64'(wr_en), 64'h0);
      chk("t5_addr_err", 64'(addr_err), 64'h1);
      chk("t5_gid", 64'(grant_id), 64'h1);
      chk("t5_wr_data", 64'(wr_data), 64'h1001);
      step();
      chk("t5_err_pulse", 64'(addr_err), 64'h0);
      req_valid = 4'b1111;
      #1;
      chk("t5_ptr_probe", 64'(req_ready), 64'h4);
      req_valid = '0;
      step();

      // Accept a write, then assert reset between edges.
      req_addr[2:0] = 3'd0;
      req_valid     = 4'b0001;
      step();
      chk("t6_wr_en", 64'(wr_en), 64'h1);
      #2;
      r_n = 1'b0;
      #1;
      chk("t6_rst_wr_en", 64'(wr_en), 64'h0);
      chk("t6_rst_gid", 64'(grant_id), 64'h0);
      chk("t6_rst_addr_err", 64'(addr_err), 64'h0);
      chk("t6_rst_ready", 64'(req_ready), 64'h0);
      step();
      r_n       = 1'b1;
      req_valid = 4'b1110;
      #1;
      chk("t6_after_ready", 64'(req_ready), 64'h2);
      req_valid = 4'b1111;
      #1;
      chk("t6_after_ready_all", 64'(req_ready), 64'h1);
      step();
      req_valid = '0;
      chk("t6_after_gid", 64'(grant_id), 64'h0);
      chk("t6_after_wr_en", 64'(wr_en), 64'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      failures++;
      $display("FAIL timeout observed=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
Round-robin write arbiter for a bank of NUM_REGS enabled registers of WIDTH bits, each with active-high enable and reset to 0.
Lets NUM_REQ producers (PCU/PMU lanes, config path) share the bank's write side, with at most one register written per cycle.
Accepts requests through a valid/ready handshake and drives a registered one-hot enable vector plus a shared data bus into the bank.
Sits between the requesting units and the register bank.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
WIDTH, 32, data width of each register
NUM_REGS, 8, number of registers in the bank (>=2)
ADDR_W, 3, register index width; must satisfy 2**ADDR_W >= NUM_REGS
ID_W, 2, grant index width; must satisfy 2**ID_W >= NUM_REQ

Ports:
clk  input  1  clock, all state on rising edge
r_n  input  1  reset, asynchronous, active-low
stall  input  1  bank busy; while high, no request is granted
req_valid  input  NUM_REQ  per-requester write request
req_ready  output  NUM_REQ  per-requester grant (combinational)
req_addr  input  NUM_REQ*ADDR_W  packed target index, requester i at [i*ADDR_W +: ADDR_W]
req_data  input  NUM_REQ*WIDTH  packed write data, requester i at [i*WIDTH +: WIDTH]
wr_en  output  NUM_REGS  registered one-hot enable to the bank
wr_data  output  WIDTH  registered data to all bank d inputs
grant_id  output  ID_W  registered index of the last accepted requester
addr_err  output  1  registered 1-cycle pulse: accepted request had out-of-range address

Behaviour:
- Reset (r_n low, asynchronous): ptr=0, wr_en=0, wr_data=0, grant_id=0, addr_err=0. req_ready is 0 while r_n is low.
- State: priority pointer ptr (0..NUM_REQ-1) and the output stage registers.
- Grant (combinational):
  - stall=1 or no req_valid -> req_ready all 0.
  - Otherwise scan indices ptr, ptr+1, ..., wrapping modulo NUM_REQ. The first i with req_valid[i]=1 gets req_ready[i]=1; all others 0.
  - At most one req_ready bit is high at any time.
- Handshake: a transfer occurs when req_valid[i] and req_ready[i] are both high at a clock edge.
  - Requesters hold valid/addr/data stable until they are accepted.
  - Deasserting valid before acceptance is legal; the request is withdrawn.
- Pointer update on a transfer by i: ptr <= (i+1) mod NUM_REQ. No transfer -> ptr holds.
  - Result: a continuously requesting input waits at most NUM_REQ-1 grants.
- Output stage, latency 1 cycle from acceptance edge to wr_en valid:
  - Transfer with addr < NUM_REGS: wr_en <= one-hot(addr), wr_data <= data, grant_id <= i, addr_err <= 0.
  - Transfer with addr >= NUM_REGS: wr_en <= 0, wr_data <= data, grant_id <= i, addr_err <= 1. The request counts as consumed and ptr advances.
  - No transfer: wr_en <= 0, addr_err <= 0; wr_data and grant_id hold.
- The bank captures on the edge after wr_en asserts, so a write is architecturally visible 2 edges after acceptance.
- stall is sampled combinationally in the same cycle. A grant already registered in wr_en is not cancelled by a later stall.
- Back-to-back: one write per cycle is sustained; consecutive cycles may target the same register (last write wins).
- Reset mid-operation: any pending wr_en is cleared immediately and ptr returns to 0. No partial write reaches the bank after r_n falls.
- Invariant: wr_en has zero or one bit set at every cycle.

Test Plan:
- Reset, then req_valid=0001, addr0=5, data0=0xDEADBEEF -> req_ready=0001 same cycle; next cycle wr_en=0x20, wr_data=0xDEADBEEF, grant_id=0; ptr=1.
- All four valid continuously for 8 cycles, ptr=0 -> grant order 0,1,2,3,0,1,2,3 with one ready bit per cycle; wr_en one-hot each cycle.
- ptr=2, req_valid=0011 -> requester 0 granted (wrap-around); ptr becomes 1.
- stall=1 with req_valid=1111 for 3 cycles -> req_ready=0 and wr_en=0 for those cycles; ptr unchanged. After stall falls, the grant goes to the ptr position.
- NUM_REGS=6, requester 1 writes addr=7 -> accepted; next cycle wr_en=0, addr_err=1 for one cycle, grant_id=1; ptr=2.
- Transfer accepted, then r_n pulled low mid-cycle before the next edge -> wr_en=0, grant_id=0, addr_err=0 immediately. After r_n rises, the first grant follows ptr=0 priority.
